// File: rtl/overlay_pkg.sv
// Shared types and helpers for the overlay triple-buffer scheduler.
package overlay_pkg;

  typedef logic [1:0] buf_idx_t;

  localparam int unsigned NUM_OVERLAY_BUFFERS = 3;
  localparam logic [31:0] DEFAULT_FRAME_BYTES = 32'h0004_B000;

  // Indices are always distinct members of {0,1,2}, so the remaining one is 3 - a - b.
  function automatic buf_idx_t third(input buf_idx_t a, input buf_idx_t b);
    return buf_idx_t'(2'd3 - a - b);
  endfunction

endpackage

// File: rtl/overlay_vsync_edge.sv
// Two-flop vsync synchronizer, polarity normalisation and one-cycle frame-start detect.
module overlay_vsync_edge #(
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic vs_edge
);

  localparam logic IdleLevel = VSYNC_ACTIVE_LOW;

  logic sync1_q, sync2_q, prev_q;
  logic active;

  assign active  = sync2_q ^ VSYNC_ACTIVE_LOW;
  assign vs_edge = active & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IdleLevel;
      sync2_q <= IdleLevel;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= vsync;
      sync2_q <= sync1_q;
      prev_q  <= active;
    end
  end

endmodule

// File: rtl/overlay_buffer_scheduler.sv
// Triple-buffer scheduler for the overlay frame store; swaps the display buffer on vsync.
// Optional statistics counters are built when OVERLAY_SCHED_STATS_EN is defined.
module overlay_buffer_scheduler
  import overlay_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter logic [31:0] FRAME_BYTES      = DEFAULT_FRAME_BYTES,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vsync,
  input  logic        wr_done,
  output logic [1:0]  wr_buffer,
  output logic [1:0]  rd_buffer,
  output logic [31:0] wr_base,
  output logic [31:0] rd_base,
  output logic        pending,
  output logic        swap,
  output logic [15:0] drop_count,
  output logic [15:0] frame_count
);

  function automatic logic [31:0] base_of(input buf_idx_t idx);
    return BASE_ADDR + 32'(idx) * FRAME_BYTES;
  endfunction

  logic     vs_edge;
  buf_idx_t wr_q, wr_d, rd_q, rd_d;
  logic     pend_q, pend_d, swap_q, swap_d;
  logic [31:0] wr_base_q, rd_base_q;

  overlay_vsync_edge #(
    .VSYNC_ACTIVE_LOW(VSYNC_ACTIVE_LOW)
  ) u_vsync_edge (
    .clk    (clk),
    .reset  (reset),
    .vsync  (vsync),
    .vs_edge(vs_edge)
  );

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    pend_d = pend_q;
    swap_d = 1'b0;
    if (enable) begin
      if (wr_done && vs_edge) begin
        // The frame just finished goes straight to display; any older pending frame is dropped.
        rd_d   = wr_q;
        wr_d   = third(wr_q, rd_q);
        pend_d = 1'b0;
        swap_d = 1'b1;
      end else if (wr_done) begin
        wr_d   = third(wr_q, rd_q);
        pend_d = 1'b1;
      end else if (vs_edge && pend_q) begin
        rd_d   = third(wr_q, rd_q);
        pend_d = 1'b0;
        swap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= 2'd1;
      rd_q      <= 2'd0;
      pend_q    <= 1'b0;
      swap_q    <= 1'b0;
      wr_base_q <= BASE_ADDR + FRAME_BYTES;
      rd_base_q <= BASE_ADDR;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      pend_q    <= pend_d;
      swap_q    <= swap_d;
      wr_base_q <= base_of(wr_d);
      rd_base_q <= base_of(rd_d);
    end
  end

`ifdef OVERLAY_SCHED_STATS_EN
  logic [15:0] drop_q, frame_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q  <= 16'h0000;
      frame_q <= 16'h0000;
    end else begin
      if (enable && wr_done && pend_q && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (swap_d) begin
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  assign drop_count  = drop_q;
  assign frame_count = frame_q;
`else
  assign drop_count  = 16'h0000;
  assign frame_count = 16'h0000;
`endif

  assign wr_buffer = wr_q;
  assign rd_buffer = rd_q;
  assign wr_base   = wr_base_q;
  assign rd_base   = rd_base_q;
  assign pending   = pend_q;
  assign swap      = swap_q;

endmodule

// File: tb/tb_overlay_buffer_scheduler.sv
// Directed bench for overlay_buffer_scheduler with a swap scoreboard.
module tb_overlay_buffer_scheduler;

  localparam logic [31:0] FB = 32'h0004_B000;
`ifdef OVERLAY_SCHED_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  typedef struct {
    logic [1:0]  rd;
    logic [31:0] base;
    logic [15:0] frames;
  } swap_exp_t;

  logic        clk = 1'b0;
  logic        reset, enable, vsync, wr_done;
  logic [1:0]  wr_buffer, rd_buffer;
  logic [31:0] wr_base, rd_base;
  logic        pending, swap;
  logic [15:0] drop_count, frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  swap_exp_t sb[$];

  overlay_buffer_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .vsync      (vsync),
    .wr_done    (wr_done),
    .wr_buffer  (wr_buffer),
    .rd_buffer  (rd_buffer),
    .wr_base    (wr_base),
    .rd_base    (rd_base),
    .pending    (pending),
    .swap       (swap),
    .drop_count (drop_count),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cnt(input int v);
    return Stats ? 16'(v) : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_swap(input logic [1:0] rd, input logic [15:0] frames);
    swap_exp_t e;
    e.rd     = rd;
    e.base   = 32'(rd) * FB;
    e.frames = frames;
    sb.push_back(e);
  endtask

  task automatic chk_state(input string tag, input logic [1:0] wr, input logic [1:0] rd,
                           input logic pend, input int drops, input int frames);
    chk({tag, ".wr_buffer"}, 32'(wr_buffer), 32'(wr));
    chk({tag, ".rd_buffer"}, 32'(rd_buffer), 32'(rd));
    chk({tag, ".wr_base"}, wr_base, 32'(wr) * FB);
    chk({tag, ".rd_base"}, rd_base, 32'(rd) * FB);
    chk({tag, ".pending"}, 32'(pending), 32'(pend));
    chk({tag, ".drop_count"}, 32'(drop_count), 32'(cnt(drops)));
    chk({tag, ".frame_count"}, 32'(frame_count), 32'(cnt(frames)));
  endtask

  // Every observed swap pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && swap === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_swap", 32'(swap), 32'd0);
      end else begin
        swap_exp_t e;
        e = sb.pop_front();
        chk("sb.rd_buffer", 32'(rd_buffer), 32'(e.rd));
        chk("sb.rd_base", rd_base, e.base);
        chk("sb.frame_count", 32'(frame_count), 32'(e.frames));
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; vsync = 1'b1; wr_done = 1'b0;
    tick(); tick();
    chk("reset.swap", 32'(swap), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    chk_state("idle", 2'd1, 2'd0, 1'b0, 0, 0);

    // Single frame then vsync: swap lands two edges after the first low sample.
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    chk_state("done1", 2'd2, 2'd0, 1'b1, 0, 0);
    vsync = 1'b0;
    push_swap(2'd1, cnt(1));
    tick();
    chk("vs.k.rd_buffer", 32'(rd_buffer), 32'd0);
    tick();
    chk("vs.k1.rd_buffer", 32'(rd_buffer), 32'd0);
    chk("vs.k1.swap", 32'(swap), 32'd0);
    tick();
    chk("vs.k2.swap", 32'(swap), 32'd1);
    chk_state("vs.k2", 2'd2, 2'd1, 1'b0, 0, 1);
    tick();
    chk("vs.k3.swap", 32'(swap), 32'd0);
    repeat (7) tick();
    vsync = 1'b1;
    repeat (4) tick();
    chk_state("vs.after", 2'd2, 2'd1, 1'b0, 0, 1);

    // Three completions without vsync: older pending frames get overwritten.
    reset = 1'b1; tick(); reset = 1'b0;
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    chk("drop.p1.wr_buffer", 32'(wr_buffer), 32'd2);
    tick();
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    chk("drop.p2.wr_buffer", 32'(wr_buffer), 32'd1);
    tick();
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    chk_state("drop.p3", 2'd2, 2'd0, 1'b1, 2, 0);

    // wr_done coincides with the internal vs_edge while a frame is pending.
    vsync = 1'b0;
    tick(); tick();
    wr_done = 1'b1;
    push_swap(2'd2, cnt(1));
    tick();
    wr_done = 1'b0;
    chk("coin.swap", 32'(swap), 32'd1);
    chk_state("coin", 2'd1, 2'd2, 1'b0, 3, 1);
    repeat (4) tick();
    vsync = 1'b1;
    repeat (4) tick();

    // Disabled: completions and vsync are ignored.
    enable = 1'b0;
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    vsync = 1'b0; repeat (5) tick(); vsync = 1'b1; repeat (4) tick();
    chk_state("disabled", 2'd1, 2'd2, 1'b0, 3, 1);

    // Enabled vsync with nothing pending produces no swap.
    enable = 1'b1;
    vsync = 1'b0;
    tick(); tick(); tick();
    chk("nopend.swap", 32'(swap), 32'd0);
    repeat (3) tick();
    vsync = 1'b1;
    repeat (4) tick();
    chk_state("nopend", 2'd1, 2'd2, 1'b0, 3, 1);

    // Reset with a frame pending and enable low returns everything to reset values.
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    chk_state("prerst", 2'd0, 2'd2, 1'b1, 3, 1);
    enable = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    enable = 1'b1;
    chk("rst.swap", 32'(swap), 32'd0);
    chk_state("rst", 2'd1, 2'd0, 1'b0, 0, 0);
    repeat (3) tick();

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
